// File: rtl/imem_dmem_responder.sv
// Instruction/data memory responder with a program-load FSM that holds the core in reset until loaded.
// Optional: define MEM_MISALIGN_CHECK_EN to flag misaligned fetches/stores and drop misaligned stores.
module imem_dmem_responder #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256,
    parameter int RESET_HOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] Instr,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        core_reset,
    output logic        load_done,
    output logic        misalign_err
);
    localparam int IAW    = $clog2(IMEM_WORDS);
    localparam int DAW    = $clog2(DMEM_WORDS);
    localparam int CNT_W  = IAW + 1;
    localparam int HOLD_W = $clog2(RESET_HOLD) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  ld_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              core_reset_q;
    logic              load_done_q;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic           ld_fire;
    logic [IAW-1:0] fetch_idx;
    logic           fetch_hit;
    logic [DAW-1:0] data_idx;
    logic           data_in_range;
    logic           store_aligned;
    logic           store_en;

    assign ld_ready      = (state_q == LOAD);
    assign ld_fire       = ld_valid && ld_ready;
    assign core_reset    = core_reset_q;
    assign load_done     = load_done_q;

    // Only words loaded since the last reset are visible; anything else fetches a NOP.
    assign fetch_idx     = PC[IAW+1:2];
    assign fetch_hit     = (state_q == RUN) && (PC[31:IAW+2] == '0) && ({1'b0, fetch_idx} < ld_cnt_q);
    assign Instr         = fetch_hit ? imem[fetch_idx] : NOP;

    assign data_idx      = ALUResult[DAW+1:2];
    assign data_in_range = (ALUResult[31:DAW+2] == '0);
    assign ReadData      = data_in_range ? dmem[data_idx] : '0;
    assign store_en      = (state_q == RUN) && MemWrite && data_in_range && store_aligned;

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_q;
    logic misalign_now;

    assign misalign_now  = (PC[1:0] != 2'b00) || (MemWrite && (ALUResult[1:0] != 2'b00));
    assign store_aligned = (ALUResult[1:0] == 2'b00);
    assign misalign_err  = misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if ((state_q == RUN) && misalign_now) begin
            misalign_q <= 1'b1;
        end
    end
`else
    logic unusedAddrBits;

    assign unusedAddrBits = ^{PC[1:0], ALUResult[1:0]};
    assign store_aligned  = 1'b1;
    assign misalign_err   = 1'b0;
`endif

    // Outputs are registered from the current state, so core_reset drops one edge after entering RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            ld_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
        end else begin
            core_reset_q <= (state_q != RUN);
            load_done_q  <= (state_q == RUN);
            case (state_q)
                LOAD: begin
                    if (ld_fire) begin
                        ld_cnt_q <= ld_cnt_q + CNT_W'(1);
                        if (ld_last || (ld_cnt_q == CNT_W'(IMEM_WORDS - 1))) begin
                            state_q    <= HOLD;
                            hold_cnt_q <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_W'(RESET_HOLD - 1)) begin
                        state_q <= RUN;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ld_fire) begin
            imem[ld_cnt_q[IAW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            dmem[data_idx] <= WriteData;
        end
    end

endmodule
